// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: receive side of a 4-slot time-division link.
//
// A serial stream carries slots 0,1,2,3 per frame; 'frame' tags slot 0. Slots 0..2 are
// staged internally. On slot 3 the frame is published on out1..out4 together with a
// one-cycle 'valid' pulse.
//
// Parameters:
//   WIDTH     bits per slot
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   in        serial slot data, sampled when en=1
//   en        sample enable, one slot per en cycle
//   frame     marks the current sample as slot 0 (qualified by en)
//   out1..4   published slot 0..3 data
//   sel       slot index expected at the next en sample (0 while hunting)
//   valid     one-cycle pulse: out1..out4 updated on this edge
//   locked    high while synchronised
//   sync_err  one-cycle pulse on a framing violation
//
// Build option: define TDM_DEMUX_STRICT_SYNC_EN to require 'frame' on every slot 0
// while locked. Without it, slot 0 is taken positionally once locked.

module tdm_demux_1_4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             frame,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [1:0]       sel,
  output logic             valid,
  output logic             locked,
  output logic             sync_err
);

`ifdef TDM_DEMUX_STRICT_SYNC_EN
  localparam bit StrictSync = 1'b1;
`else
  localparam bit StrictSync = 1'b0;
`endif

  typedef enum logic [0:0] {StHunt, StSync} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] staging_q [3];
  logic [WIDTH-1:0] staging_d [3];
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic             valid_q, valid_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    staging_d  = staging_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (frame) begin
            staging_d[0] = in;
            sel_d        = 2'd1;
            state_d      = StSync;
          end
        end
        StSync: begin
          if (frame && (sel_q != 2'd0)) begin
            // Early frame: drop the partial frame and restart at slot 0 with this sample.
            sync_err_d   = 1'b1;
            staging_d[0] = in;
            sel_d        = 2'd1;
          end else if (StrictSync && !frame && (sel_q == 2'd0)) begin
            // Missing frame at slot 0: lose lock.
            sync_err_d = 1'b1;
            sel_d      = 2'd0;
            state_d    = StHunt;
          end else begin
            unique case (sel_q)
              2'd0: staging_d[0] = in;
              2'd1: staging_d[1] = in;
              2'd2: staging_d[2] = in;
              2'd3: begin
                // Slot 3 goes straight to the output without staging.
                out_d[0] = staging_q[0];
                out_d[1] = staging_q[1];
                out_d[2] = staging_q[2];
                out_d[3] = in;
                valid_d  = 1'b1;
              end
              default: ;
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StHunt;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      for (int i = 0; i < 3; i++) staging_q[i] <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
      staging_q  <= staging_d;
      out_q      <= out_d;
    end
  end

  assign out1     = out_q[0];
  assign out2     = out_q[1];
  assign out3     = out_q[2];
  assign out4     = out_q[3];
  assign sel      = sel_q;
  assign valid    = valid_q;
  assign sync_err = sync_err_q;
  assign locked   = (state_q == StSync);

endmodule

// File: tb/tb_tdm_demux_1_4.sv
module tb_tdm_demux_1_4;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] in;
  logic       en;
  logic       frame;
  logic [0:0] out1, out2, out3, out4;
  logic [1:0] sel;
  logic       valid, locked, sync_err;

  int tests = 0;
  int fails = 0;

  tdm_demux_1_4 #(.WIDTH(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .en       (en),
    .frame    (frame),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .sel      (sel),
    .valid    (valid),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // Observed state packed as {sel, valid, locked, sync_err, out1, out2, out3, out4}.
  typedef struct packed {
    logic       en;
    logic       frame;
    logic       in_bit;
    logic [1:0] sel;
    logic       valid;
    logic       locked;
    logic       err;
    logic [3:0] outs;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs [NumVec];

  function automatic logic [8:0] observed();
    return {sel, valid, locked, sync_err, out1, out2, out3, out4};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got sel/v/lk/err/outs=%b required %b", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic f, input logic d);
    en    = e;
    frame = f;
    in    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {en, frame, in, sel, valid, locked, err, outs}
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000}; // hunt discards
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'b0000}; // acquire
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1011}; // frame 1,0,1,1
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1011}; // en gap
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0110}; // frame 0,1,1,0
    vecs[13] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0110}; // early frame
    vecs[16] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1101}; // frame 1,1,0,1
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    vecs[19] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1101}; // missing frame
    vecs[20] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1101};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1101};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1101};
`else
    vecs[19] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 4'b1101}; // positional slot 0
    vecs[20] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1101};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'b1101};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0110};
`endif

    reset = 1'b1;
    en    = 1'b0;
    frame = 1'b0;
    in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(), 9'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].en, vecs[i].frame, vecs[i].in_bit);
      check($sformatf("vec%0d", i), observed(),
            {vecs[i].sel, vecs[i].valid, vecs[i].locked, vecs[i].err, vecs[i].outs});
    end

    // Asynchronous reset mid-frame at sel=2; outputs must clear with no clock edge.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("pre_reset_sel2", {sel, locked}, {2'd2, 1'b1});
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", observed(), 9'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First sample after release is evaluated in HUNT.
    step(1'b1, 1'b0, 1'b1);
    check("hunt_after_reset", observed(), 9'b0);

    // Fresh frame 1,0,1,1 from HUNT: sel 1,2,3,0 with valid after the 4th sample.
    step(1'b1, 1'b1, 1'b1);
    check("relock_s0", observed(), {2'd1, 1'b0, 1'b1, 1'b0, 4'b0000});
    step(1'b1, 1'b0, 1'b0);
    check("relock_s1", observed(), {2'd2, 1'b0, 1'b1, 1'b0, 4'b0000});
    step(1'b1, 1'b0, 1'b1);
    check("relock_s2", observed(), {2'd3, 1'b0, 1'b1, 1'b0, 4'b0000});
    step(1'b1, 1'b0, 1'b1);
    check("relock_valid", observed(), {2'd0, 1'b1, 1'b1, 1'b0, 4'b1011});
    step(1'b0, 1'b0, 1'b0);
    check("valid_one_cycle", observed(), {2'd0, 1'b0, 1'b1, 1'b0, 4'b1011});

    // en=0 in HUNT with frame high must not acquire.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    check("no_lock_without_en", observed(), 9'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_4.md
# tdm_demux_1_4

Time-division demultiplexer: the receive-side counterpart of the 4:1 select mux. A single serial stream carries four slots per frame, in slot order 0,1,2,3. A frame strobe marks slot 0. The block steers each slot into a staging register and publishes all four as a registered parallel word with a one-cycle valid pulse. It sits between a TDM link or multiplexed bus and the lane consumers.

## Interface
Parameters:
- WIDTH, 1, bits per slot (the lane data width).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  serial slot data, sampled when en=1.
- en  input  1  sample enable; one slot is consumed per cycle with en=1.
- frame  input  1  marks the current sample as slot 0; qualified by en.
- out1  output  WIDTH  slot 0 data (the lane the mux drives at sel=2'b00).
- out2  output  WIDTH  slot 1 data (sel=2'b01).
- out3  output  WIDTH  slot 2 data (sel=2'b10).
- out4  output  WIDTH  slot 3 data (sel=2'b11).
- sel  output  2  slot index expected at the next en sample.
- valid  output  1  one-cycle pulse; out1..out4 were updated on this edge.
- locked  output  1  high while the state is SYNC.
- sync_err  output  1  one-cycle pulse on a detected framing violation.

## Operation
- The state machine has two states, HUNT and SYNC. Reset enters HUNT.
- HUNT:
  - en=1 with frame=0 discards the sample.
  - en=1 with frame=1 captures in into staging[0], sets sel to 1, and moves to SYNC.
- SYNC, en=1 and frame=0:
  - in is captured into staging[sel] and sel increments modulo 4.
  - When sel was 3, out1..out4 load staging[0..2] together with the current in (slot 3 bypasses staging). valid pulses.
- SYNC, en=1, frame=1, sel=0: this is a normal slot-0 capture. Treat it like the frame=0 case with sel=0.
- SYNC, en=1, frame=1, sel≠0 (early frame):
  - sync_err pulses and the partial frame is discarded; out1..out4 are not updated.
  - in is captured into staging[0], sel is set to 1, and the state stays SYNC.
- en=0: all state, staging, sel and outputs hold. valid=0 and sync_err=0.
- out1..out4 change only on a valid edge or on reset.
- Staging registers are not visible at the outputs.

## Timing
- Reset values: out1..out4=0, sel=0, valid=0, locked=0, sync_err=0, staging=0, state=HUNT.
- Reset is asynchronous; outputs clear immediately on reset assertion, not at the next edge.
- Reset asserted mid-frame discards the partial frame.
- The first en sample after reset deassertion is evaluated in HUNT.
- Latency: valid is asserted in the cycle after the rising edge that samples slot 3 with en=1. out1..out4 are valid in that same cycle.
- Minimum frame is 4 consecutive en cycles. With en=1 continuously, valid pulses every 4 cycles.
- Gaps in en stretch a frame arbitrarily; there is no timeout.
- valid and sync_err are registered outputs and are never high in the same cycle. An early frame never produces valid.
- sel is registered and reflects the next expected slot, not the one being sampled.
- sel reads 0 in HUNT.

## Configuration
- TDM_DEMUX_STRICT_SYNC_EN:
  - Defined: in SYNC, a sample at sel=0 with en=1 and frame=0 is a framing violation. sync_err pulses, the sample is discarded, sel resets to 0, and the state returns to HUNT (locked falls).
  - Undefined: frame is needed only to acquire lock. Slot 0 is taken positionally, and a missing frame at sel=0 is a normal capture.
- The early-frame rule applies in both builds.

## Test plan
- Reset, then en=1 continuously with WIDTH=1. Drive frame=1 on the first sample and in sequence 1,0,1,1. Required: valid exactly one cycle after the 4th sample, out1..out4=1,0,1,1, locked=1, sel sequence 1,2,3,0.
- Samples with frame=0 before any frame, in=1 each time. Required: no capture, sel=0, locked=0, outputs remain 0.
- Lock, then en=0 for 3 cycles between slot 1 and slot 2. Required: sel holds at 2, no valid during the gap, and valid arrives after slot 3 with the correct data.
- Lock, then assert frame at sel=2. Required: sync_err pulses one cycle, the previous out1..out4 are retained, sel=1, and the next 3 samples complete a frame with valid.
- Assert reset while sel=2 mid-frame. Required: all outputs 0 immediately, with no clock edge. After release, the state is HUNT.
- TDM_DEMUX_STRICT_SYNC_EN defined: after one good frame, omit frame at the next slot 0. Required: sync_err pulse, locked=0, sel=0, no valid. Undefined: the same stimulus yields a normal valid after 4 samples.
